xmit_b_arb: RTL and testbench
=============================

// Module: xmit_b_arb
// PURPOSE
//  Round-robin frame arbiter that shares one xmit_b byte transmitter between NREQ
//  requesters. A grant is held for a whole frame, from first byte to the byte
//  flagged last, so frames never interleave on the transmitter.
//  Sits between the per-channel frame sources and the single xmit_b instance.
//  A stall watchdog frees the transmitter if the granted requester stops sending.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  TIMEOUT   255  max consecutive XFER cycles with no accepted byte before abort (1..255)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       reset, asynchronous assert, active-low
//  req_valid    in   NREQ    requester i has a byte on req_data[8i+7:8i]
//  req_data     in   8*NREQ  per-requester byte
//  req_last     in   NREQ    byte on requester i is the last byte of its frame
//  req_ready    out  NREQ    byte on requester i accepted this cycle (one-hot or zero)
//  xmit_b_in1   out  8       byte to transmitter
//  xmit_b_in2   out  1       byte-valid strobe to transmitter
//  xmit_b_out1  in   1       transmitter ready to accept a byte
//  grant        out  NREQ    registered one-hot owner of the transmitter, 0 when idle
//  busy         out  1       registered, 1 while state != IDLE
//  timeout_err  out  1       registered one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset values: state=IDLE, grant=0, busy=0, timeout_err=0, rr_ptr=NREQ-1.
//   Derived outputs xmit_b_in1=0, xmit_b_in2=0, req_ready=0.
//  A byte transfers on a clock edge where xmit_b_in2 && xmit_b_out1.
//  FSM states: IDLE, XFER, ABORT.
//  IDLE:
//   - If |req_valid, pick the first valid index searching rr_ptr+1, rr_ptr+2, ...
//     modulo NREQ.
//   - Register grant=onehot(pick); go to XFER. Arbitration latency is 1 cycle.
//  XFER, g = granted index:
//   - xmit_b_in1 = req_data[g]; xmit_b_in2 = req_valid[g].
//   - req_ready[g] = req_valid[g] && xmit_b_out1.
//   - These paths are combinational and carry no added latency.
//   - Transfer with req_last[g] => next state IDLE, grant=0, rr_ptr=g.
//   - Back-to-back frames from different requesters are therefore separated by
//     exactly 1 idle cycle.
//   - Stall counter resets to 0 on every transfer and increments otherwise.
//   - Stall counter reaches TIMEOUT => next state ABORT.
//  ABORT (1 cycle):
//   - grant=0, xmit_b_in2=0, timeout_err=1, rr_ptr=g; next state IDLE.
//   - The aborted requester loses its turn; its frame is truncated.
//  Outside XFER: xmit_b_in2=0, req_ready=0, xmit_b_in1=0.
//  Non-granted requesters never see req_ready; their valid/data are ignored and
//  they must hold them.
//  req_valid deasserting mid-frame is legal (bubble) and counts toward the timeout.
//  Single-byte frame (valid and last together) = one transfer, then IDLE.
//  rst_n low mid-frame: immediate return to reset values; the partial frame is
//  dropped with no error pulse.
//  Stall counter width = $clog2(TIMEOUT+1); it saturates and never wraps.
// STRUCTURE
//  Shared package xmit_pkg:
//   - state enum {IDLE, XFER, ABORT}
//   - XMIT_BYTE_W = 8
//   - default TIMEOUT constant
//  Sub-module rr_pick (combinational, NREQ param): inputs req vector and rr_ptr,
//  output one-hot pick and any_valid. Reused by later arbiters.
//  Top level holds the FSM, stall counter, rr_ptr and the output mux.
// TESTING
//  1. Reset, then req_valid=4'b0001, 3-byte frame 0xA1,0xA2,0xA3 (last on 0xA3),
//     xmit_b_out1=1 -> grant=0001 one cycle after request, 3 strobes, grant=0
//     after 0xA3.
//  2. All four requesters valid with 2-byte frames -> grant order 0,1,2,3,0,
//     1 idle cycle between frames, no byte interleave.
//  3. Requester 2 mid-frame, xmit_b_out1=0 for 10 cycles -> xmit_b_in1 holds the
//     byte, req_ready=0, no timeout; transfer completes when ready returns.
//  4. TIMEOUT=8, grantee drops req_valid mid-frame -> ABORT after 8 stall cycles,
//     timeout_err one-cycle pulse, next grant goes to requester g+1 if valid.
//  5. rst_n pulsed low during byte 2 of a frame -> grant=0, busy=0, xmit_b_in2=0
//     immediately; after release, requester 0 wins first.
//  6. Single-byte frames 0x55 from requesters 1 and 3 simultaneously ->
//     1 granted first, then 3; exactly one strobe each.

Source files
------------

// File: rtl/xmit_pkg.sv
// Shared types and constants for the xmit_b transmitter arbiters.
package xmit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } xmit_state_e;

  localparam int XMIT_BYTE_W      = 8;
  localparam int XMIT_TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         pick,
  output logic                    any_valid
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] idx;

  // Scan from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/xmit_b_arb.sv
// Round-robin frame arbiter sharing one xmit_b transmitter, with stall watchdog.
module xmit_b_arb
  import xmit_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = XMIT_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [XMIT_BYTE_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic [XMIT_BYTE_W-1:0]      xmit_b_in1,
  output logic                        xmit_b_in2,
  input  logic                        xmit_b_out1,
  output logic [NREQ-1:0]             grant,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STALL_LIM = CW'(TIMEOUT);
  localparam logic [CW-1:0] STALL_MAX = '1;

  xmit_state_e   state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g_idx;
  logic [PW-1:0] pick_idx;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_nxt;
  logic [NREQ-1:0] pick;
  logic          any_valid;
  logic          in_xfer;
  logic          xfer_ok;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Transmitter path is a pure mux on the registered owner: no added latency.
  assign in_xfer    = (state == XFER);
  assign xmit_b_in1 = in_xfer ? req_data[g_idx*XMIT_BYTE_W +: XMIT_BYTE_W] : '0;
  assign xmit_b_in2 = in_xfer & req_valid[g_idx];
  assign req_ready  = in_xfer ? (grant & req_valid & {NREQ{xmit_b_out1}}) : '0;
  assign xfer_ok    = xmit_b_in2 & xmit_b_out1;
  assign stall_nxt  = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= PW'(NREQ - 1);
      g_idx       <= '0;
      stall_cnt   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            state     <= XFER;
            grant     <= pick;
            g_idx     <= pick_idx;
            busy      <= 1'b1;
            stall_cnt <= '0;
          end
        end
        XFER: begin
          if (xfer_ok) begin
            stall_cnt <= '0;
            if (req_last[g_idx]) begin
              state  <= IDLE;
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= g_idx;
            end
          end else if (stall_nxt >= STALL_LIM) begin
            // Aborted owner gives up its turn; the frame is truncated.
            state       <= ABORT;
            grant       <= '0;
            timeout_err <= 1'b1;
            rr_ptr      <= g_idx;
            stall_cnt   <= '0;
          end else begin
            stall_cnt <= stall_nxt;
          end
        end
        ABORT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xmit_b_arb.sv
// Bench for xmit_b_arb: two instances (default and short watchdog) against a frame-level model.
module tb_xmit_b_arb;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic           out1 = 1'b1;

  logic [N-1:0] ready_w [2];
  logic [N-1:0] grant_w [2];
  logic [7:0]   in1_w   [2];
  logic         in2_w   [2];
  logic         busy_w  [2];
  logic         terr_w  [2];

  always #5 clk = ~clk;

  xmit_b_arb #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_w[0]), .xmit_b_in1(in1_w[0]),
    .xmit_b_in2(in2_w[0]), .xmit_b_out1(out1), .grant(grant_w[0]),
    .busy(busy_w[0]), .timeout_err(terr_w[0])
  );

  xmit_b_arb #(.NREQ(N), .TIMEOUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_w[1]), .xmit_b_in1(in1_w[1]),
    .xmit_b_in2(in2_w[1]), .xmit_b_out1(out1), .grant(grant_w[1]),
    .busy(busy_w[1]), .timeout_err(terr_w[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- frame sources ----------------
  logic [7:0] sbyte [N][32];
  logic       slast [N][32];
  int         shead [N];
  int         stail [N];
  logic [N-1:0] hold = '0;
  logic [N-1:0] rdy_s;
  int         drv = 0;

  task automatic push(input int r, input logic [7:0] b, input logic l);
    sbyte[r][stail[r]] = b;
    slast[r][stail[r]] = l;
    stail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = (shead[i] < stail[i]) && !hold[i];
      req_data[i*8 +: 8]  = sbyte[i][shead[i]];
      req_last[i]         = slast[i][shead[i]];
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      shead[i] = 0;
      stail[i] = 0;
      for (int j = 0; j < 32; j++) begin
        sbyte[i][j] = 8'h00;
        slast[i][j] = 1'b0;
      end
    end
    hold = '0;
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
    rdy_s = ready_w[drv];
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) if (rdy_s[i]) shead[i]++;
    drive();
  endtask

  // ---------------- observation logs ----------------
  logic [11:0] xlog0 [$];
  logic [11:0] xlog1 [$];
  logic [11:0] glog0 [$];
  logic [11:0] glog1 [$];
  logic [11:0] eq [$];
  logic [11:0] pend [2];
  logic        pv [2];
  logic [N-1:0] gprev [2];
  int idle0 = 0;
  int terr_cnt [2];

  function automatic logic [3:0] oh2i(input logic [N-1:0] v);
    oh2i = 4'hF;
    for (int i = 0; i < N; i++) if (v[i]) oh2i = 4'(i);
  endfunction

  task automatic clear_logs();
    xlog0.delete(); xlog1.delete(); glog0.delete(); glog1.delete();
    idle0 = 0;
    terr_cnt[0] = 0;
    terr_cnt[1] = 0;
    gprev[0] = '0;
    gprev[1] = '0;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pv[k]   = in2_w[k] && out1;
      pend[k] = {oh2i(grant_w[k]), in1_w[k]};
      if (grant_w[k] != '0 && gprev[k] == '0) begin
        if (k == 0) glog0.push_back({8'h00, oh2i(grant_w[k])});
        else        glog1.push_back({8'h00, oh2i(grant_w[k])});
      end
      gprev[k] = grant_w[k];
      if (terr_w[k]) terr_cnt[k]++;
    end
    if (rst_n && !busy_w[0] && req_valid != '0) idle0++;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (pv[0]) xlog0.push_back(pend[0]);
      if (pv[1]) xlog1.push_back(pend[1]);
    end
  end

  // ---------------- frame-level reference model ----------------
  int m_own   [2] = '{-1, -1};
  int m_rr    [2] = '{N-1, N-1};
  int m_stall [2] = '{0, 0};
  bit m_ab    [2] = '{1'b0, 1'b0};
  int m_to    [2] = '{255, 8};

  always @(posedge clk or negedge rst_n) begin
    int c;
    int o;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_own[k] = -1; m_rr[k] = N - 1; m_stall[k] = 0; m_ab[k] = 1'b0;
      end else if (m_ab[k]) begin
        m_ab[k] = 1'b0;
      end else if (m_own[k] < 0) begin
        for (int j = 1; j <= N; j++) begin
          c = (m_rr[k] + j) % N;
          if (m_own[k] < 0 && req_valid[c]) m_own[k] = c;
        end
        m_stall[k] = 0;
      end else begin
        o = m_own[k];
        if (req_valid[o] && out1) begin
          m_stall[k] = 0;
          if (req_last[o]) begin
            m_rr[k] = o;
            m_own[k] = -1;
          end
        end else begin
          m_stall[k]++;
          if (m_stall[k] >= m_to[k]) begin
            m_rr[k] = o; m_own[k] = -1; m_ab[k] = 1'b1; m_stall[k] = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [7:0]   e1;
    logic         e2;
    for (int k = 0; k < 2; k++) begin
      eg = '0; er = '0; e1 = 8'h00; e2 = 1'b0;
      if (m_own[k] >= 0) begin
        eg[m_own[k]] = 1'b1;
        e1 = req_data[m_own[k]*8 +: 8];
        e2 = req_valid[m_own[k]];
        if (req_valid[m_own[k]] && out1) er[m_own[k]] = 1'b1;
      end
      chk($sformatf("grant%0d", k),  grant_w[k], eg);
      chk($sformatf("ready%0d", k),  ready_w[k], er);
      chk($sformatf("in1_%0d", k),   in1_w[k], e1);
      chk($sformatf("in2_%0d", k),   in2_w[k], e2);
      chk($sformatf("busy%0d", k),   busy_w[k], (m_own[k] >= 0) || m_ab[k]);
      chk($sformatf("terr%0d", k),   terr_w[k], m_ab[k]);
    end
  end

  // ---------------- hand-computed expectations ----------------
  task automatic chk_q(input string nm, input int which);
    logic [11:0] a [$];
    case (which)
      0: a = xlog0;
      1: a = xlog1;
      2: a = glog0;
      default: a = glog1;
    endcase
    chk({nm, "_len"}, a.size(), eq.size());
    for (int i = 0; i < eq.size(); i++)
      chk(nm, (i < a.size()) ? a[i] : 12'hFFF, eq[i]);
    eq.delete();
  endtask

  task automatic ex(input logic [11:0] v);
    eq.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    drive();
    clear_logs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    clear_src();
    clear_logs();
    drive();

    // 1: single 3-byte frame from requester 0
    do_reset();
    push(0, 8'hA1, 0); push(0, 8'hA2, 0); push(0, 8'hA3, 1); drive();
    for (int c = 0; c < 20 && xlog0.size() < 3; c++) cycle();
    repeat (2) cycle();
    ex(12'h0A1); ex(12'h0A2); ex(12'h0A3); chk_q("t1_xfer", 0);
    ex(12'h000); chk_q("t1_grant", 2);
    chk("t1_arb_idle", idle0, 1);

    // 2: all four requesters, 2-byte frames, requester 0 has two frames
    do_reset();
    push(0, 8'h00, 0); push(0, 8'h01, 1); push(0, 8'h02, 0); push(0, 8'h03, 1);
    for (int r = 1; r < N; r++) begin
      push(r, 8'(r*16), 0); push(r, 8'(r*16 + 1), 1);
    end
    drive();
    for (int c = 0; c < 60 && xlog0.size() < 10; c++) cycle();
    repeat (2) cycle();
    ex(12'h000); ex(12'h001); ex(12'h110); ex(12'h111); ex(12'h220);
    ex(12'h221); ex(12'h330); ex(12'h331); ex(12'h002); ex(12'h003);
    chk_q("t2_xfer", 0);
    ex(12'h000); ex(12'h001); ex(12'h002); ex(12'h003); ex(12'h000);
    chk_q("t2_grant", 2);
    chk("t2_idle_gaps", idle0, 5);

    // 3: transmitter not ready for 10 cycles mid-frame
    do_reset();
    push(2, 8'hC0, 0); push(2, 8'hC1, 0); push(2, 8'hC2, 0); push(2, 8'hC3, 1); drive();
    for (int c = 0; c < 10 && xlog0.size() < 1; c++) cycle();
    out1 = 1'b0;
    repeat (10) cycle();
    out1 = 1'b1;
    for (int c = 0; c < 20 && xlog0.size() < 4; c++) cycle();
    repeat (2) cycle();
    ex(12'h2C0); ex(12'h2C1); ex(12'h2C2); ex(12'h2C3); chk_q("t3_xfer", 0);
    chk("t3_no_timeout", terr_cnt[0], 0);
    chk("t3_short_wd_abort", terr_cnt[1], 1);

    // 4: grantee of the short-watchdog instance drops valid mid-frame
    do_reset();
    drv = 1;
    push(1, 8'hD0, 0); push(1, 8'hD1, 0); push(1, 8'hD2, 1); push(2, 8'hE0, 1); drive();
    for (int c = 0; c < 10 && xlog1.size() < 1; c++) cycle();
    hold[1] = 1'b1; drive();
    repeat (12) cycle();
    hold[1] = 1'b0; drive();
    for (int c = 0; c < 20 && xlog1.size() < 4; c++) cycle();
    repeat (2) cycle();
    ex(12'h1D0); ex(12'h2E0); ex(12'h1D1); ex(12'h1D2); chk_q("t4_xfer", 1);
    ex(12'h001); ex(12'h002); ex(12'h001); chk_q("t4_grant", 3);
    chk("t4_abort_pulse", terr_cnt[1], 1);
    chk("t4_no_abort_dflt", terr_cnt[0], 0);
    drv = 0;

    // 5: reset asserted while byte 2 of a frame is presented
    do_reset();
    push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 1); push(1, 8'h71, 1); drive();
    for (int c = 0; c < 10 && xlog0.size() < 1; c++) cycle();
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", grant_w[0], 0);
    chk("t5_rst_busy", busy_w[0], 0);
    chk("t5_rst_in2", in2_w[0], 0);
    chk("t5_rst_ready", ready_w[0], 0);
    clear_src();
    drive();
    clear_logs();
    repeat (2) @(posedge clk);
    #2;
    push(0, 8'h61, 0); push(0, 8'h62, 1); push(1, 8'h71, 1); drive();
    rst_n = 1'b1;
    for (int c = 0; c < 20 && xlog0.size() < 3; c++) cycle();
    repeat (2) cycle();
    ex(12'h061); ex(12'h062); ex(12'h171); chk_q("t5_xfer", 0);
    ex(12'h000); ex(12'h001); chk_q("t5_grant", 2);
    chk("t5_no_err", terr_cnt[0], 0);

    // 6: simultaneous single-byte frames from requesters 1 and 3
    do_reset();
    push(1, 8'h55, 1); push(3, 8'h55, 1); drive();
    for (int c = 0; c < 20 && xlog0.size() < 2; c++) cycle();
    repeat (3) cycle();
    ex(12'h155); ex(12'h355); chk_q("t6_xfer", 0);
    ex(12'h001); ex(12'h003); chk_q("t6_grant", 2);
    chk("t6_idle", idle0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
